// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider family.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

  // Width of a down-counter that must hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // All-ones quotient reported on divide-by-zero, truncated by the caller to w bits.
  function automatic logic [63:0] dbz_quot(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/divider_restore_step.sv
// One restoring-division step: shift in a numerator bit, trial-subtract, select.
module divider_restore_step #(
  parameter int unsigned DEN_W = 8
) (
  input  logic [DEN_W:0]   rem_in,
  input  logic             num_bit,
  input  logic [DEN_W-1:0] den,
  output logic [DEN_W:0]   rem_out,
  output logic             q_bit
);

  logic [DEN_W+1:0] shifted;
  logic [DEN_W+1:0] trial;

  // Partial remainder stays below den, so one guard bit suffices to see the borrow.
  always_comb begin
    shifted = {rem_in, num_bit};
    trial   = shifted - {2'b00, den};
    q_bit   = ~trial[DEN_W+1];
    rem_out = q_bit ? trial[DEN_W:0] : shifted[DEN_W:0];
  end

endmodule

// File: rtl/divider_iter_su.sv
// Iterative signed/unsigned restoring divider with valid/ready handshakes.
// Signed mode is built only when DIV_SIGNED_EN is defined.
module divider_iter_su
  import divider_pkg::*;
#(
  parameter int unsigned NUM_W = 8,
  parameter int unsigned DEN_W = 8
) (
  input  logic             tb_clk,
  input  logic             tb_srst,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_quot,
  output logic [DEN_W-1:0] out_rem,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(NUM_W);
  localparam logic [NUM_W-1:0] DBZ_QUOT = NUM_W'(dbz_quot(NUM_W));

  div_state_e       state;
  logic [NUM_W-1:0] num_r;   // operand, then magnitude, then quotient shift register
  logic [DEN_W-1:0] den_r;
  logic [DEN_W:0]   prem;
  logic [CNT_W-1:0] cnt;

  logic [NUM_W-1:0] num_mag;
  logic [DEN_W-1:0] den_mag;
  logic [NUM_W-1:0] quot_fix;
  logic [DEN_W-1:0] rem_fix;
  logic             ovf_fix;
  logic [DEN_W:0]   prem_nxt;
  logic             q_bit;

`ifdef DIV_SIGNED_EN
  logic sgn_r, q_neg, r_neg;
  logic num_neg, den_neg;

  always_comb begin
    num_neg  = sgn_r & num_r[NUM_W-1];
    den_neg  = sgn_r & den_r[DEN_W-1];
    num_mag  = num_neg ? -num_r : num_r;
    den_mag  = den_neg ? -den_r : den_r;
    quot_fix = q_neg ? -num_r : num_r;
    rem_fix  = r_neg ? -prem[DEN_W-1:0] : prem[DEN_W-1:0];
    // A positive signed quotient with MSB set can only come from MIN / -1.
    ovf_fix  = sgn_r & ~q_neg & num_r[NUM_W-1];
  end

  always_ff @(posedge tb_clk or negedge tb_srst) begin
    if (!tb_srst) begin
      sgn_r <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (ce) begin
      if (state == IDLE && in_valid) sgn_r <= in_signed;
      if (state == PREP) begin
        q_neg <= num_neg ^ den_neg;
        r_neg <= num_neg;
      end
    end
  end
`else
  logic unused_signed;
  assign unused_signed = in_signed;

  always_comb begin
    num_mag  = num_r;
    den_mag  = den_r;
    quot_fix = num_r;
    rem_fix  = prem[DEN_W-1:0];
    ovf_fix  = 1'b0;
  end
`endif

  divider_restore_step #(.DEN_W(DEN_W)) u_step (
    .rem_in  (prem),
    .num_bit (num_r[NUM_W-1]),
    .den     (den_r),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge tb_clk or negedge tb_srst) begin
    if (!tb_srst) begin
      state     <= IDLE;
      num_r     <= '0;
      den_r     <= '0;
      prem      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            num_r    <= in_num;
            den_r    <= in_den;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          if (den_r == '0) begin
            out_quot  <= DBZ_QUOT;
            out_rem   <= num_r[DEN_W-1:0];
            out_dbz   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            num_r <= num_mag;
            den_r <= den_mag;
            prem  <= '0;
            cnt   <= CNT_W'(NUM_W);
            state <= ITER;
          end
        end
        ITER: begin
          num_r <= {num_r[NUM_W-2:0], q_bit};
          prem  <= prem_nxt;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          out_quot  <= quot_fix;
          out_rem   <= rem_fix;
          out_ovf   <= ovf_fix;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_iter_su.sv
// Directed self-checking bench for divider_iter_su (NUM_W = DEN_W = 8).
module tb_divider_iter_su;

`ifdef DIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic       tb_clk    = 1'b0;
  logic       tb_srst   = 1'b1;
  logic       ce        = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_signed = 1'b0;
  logic [7:0] in_num    = '0;
  logic [7:0] in_den    = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_dbz, out_ovf, busy;
  logic [7:0] out_quot, out_rem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 tb_clk = ~tb_clk;

  divider_iter_su #(.NUM_W(8), .DEN_W(8)) dut (
    .tb_clk    (tb_clk),
    .tb_srst   (tb_srst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_num    (in_num),
    .in_den    (in_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_quot"},  32'(out_quot),  32'd0);
    check({tag, "_rem"},   32'(out_rem),   32'd0);
    check({tag, "_dbz"},   32'(out_dbz),   32'd0);
    check({tag, "_ovf"},   32'(out_ovf),   32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  // Present operands for one accept edge; returns at the falling edge after it.
  task automatic issue(input logic sgn, input logic [7:0] num, input logic [7:0] den);
    int n = 0;
    @(negedge tb_clk);
    while (!in_ready && n < 50) begin
      @(negedge tb_clk);
      n++;
    end
    check("issue_ready", 32'(in_ready), 32'd1);
    ce        = 1'b1;
    in_valid  = 1'b1;
    in_signed = sgn;
    in_num    = num;
    in_den    = den;
    @(negedge tb_clk);
    in_valid  = 1'b0;
    in_num    = 8'h5A;
    in_den    = 8'h00;
  endtask

  // Latency counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_res(input string tag, input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf, input int elat, input bit ce_tog);
    int lat = 0;
    while (!out_valid && lat < 60) begin
      if (ce_tog) ce = ~ce;
      @(negedge tb_clk);
      lat++;
    end
    check({tag, "_lat"},   32'(lat),      32'(elat));
    check({tag, "_quot"},  32'(out_quot), 32'(eq));
    check({tag, "_rem"},   32'(out_rem),  32'(er));
    check({tag, "_dbz"},   32'(out_dbz),  32'(edbz));
    check({tag, "_ovf"},   32'(out_ovf),  32'(eovf));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    ce = 1'b1;
    if (out_ready) begin
      @(negedge tb_clk);
      check({tag, "_taken"},   32'(out_valid), 32'd0);
      check({tag, "_rdy_ret"}, 32'(in_ready),  32'd1);
      check({tag, "_flg_clr"}, 32'({out_dbz, out_ovf}), 32'd0);
    end
  endtask

  initial begin
    #2 tb_srst = 1'b0;
    #1 check_idle_outputs("reset");
    @(negedge tb_clk);
    @(negedge tb_clk);
    tb_srst = 1'b1;
    ce      = 1'b1;

    issue(1'b0, 8'd200, 8'd7);
    wait_res("u200_7", 8'd28, 8'd4, 1'b0, 1'b0, 10, 1'b0);

    issue(1'b1, 8'hF9, 8'h02);
    wait_res("s_m7_2", SGN_EN ? 8'hFD : 8'h7C, SGN_EN ? 8'hFF : 8'h01, 1'b0, 1'b0, 10, 1'b0);

    issue(1'b1, 8'h07, 8'hFE);
    wait_res("s_7_m2", SGN_EN ? 8'hFD : 8'h00, SGN_EN ? 8'h01 : 8'h07, 1'b0, 1'b0, 10, 1'b0);

    issue(1'b1, 8'h9C, 8'h07);
    wait_res("s_m100_7", SGN_EN ? 8'hF2 : 8'h16, SGN_EN ? 8'hFE : 8'h02, 1'b0, 1'b0, 10, 1'b0);

    issue(1'b0, 8'd37, 8'd0);
    wait_res("u_dbz", 8'hFF, 8'd37, 1'b1, 1'b0, 1, 1'b0);

    issue(1'b1, 8'd37, 8'd0);
    wait_res("s_dbz", 8'hFF, 8'd37, 1'b1, 1'b0, 1, 1'b0);

    issue(1'b1, 8'h80, 8'hFF);
    wait_res("s_ovf", SGN_EN ? 8'h80 : 8'h00, SGN_EN ? 8'h00 : 8'h80, 1'b0, SGN_EN, 10, 1'b0);

    issue(1'b0, 8'h80, 8'hFF);
    wait_res("u_80_ff", 8'h00, 8'h80, 1'b0, 1'b0, 10, 1'b0);

    issue(1'b1, 8'h80, 8'h01);
    wait_res("s_min_1", 8'h80, 8'h00, 1'b0, 1'b0, 10, 1'b0);

    // Back-pressure with new operands waiting at the input.
    out_ready = 1'b0;
    issue(1'b0, 8'd200, 8'd7);
    wait_res("bp", 8'd28, 8'd4, 1'b0, 1'b0, 10, 1'b0);
    in_valid  = 1'b1;
    in_signed = 1'b0;
    in_num    = 8'd100;
    in_den    = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_quot",  32'(out_quot),  32'd28);
      check("bp_hold_rem",   32'(out_rem),   32'd4);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge tb_clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    @(negedge tb_clk);
    check("bp_accept_busy",  32'(busy),     32'd1);
    check("bp_accept_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_res("bp_next", 8'd33, 8'd1, 1'b0, 1'b0, 10, 1'b0);

    // Asynchronous reset in the middle of the iterations.
    issue(1'b0, 8'd200, 8'd7);
    repeat (4) @(negedge tb_clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 tb_srst = 1'b0;
    #1 check_idle_outputs("mid_rst");
    @(negedge tb_clk);
    tb_srst = 1'b1;

    issue(1'b0, 8'd255, 8'd1);
    wait_res("u255_1", 8'd255, 8'd0, 1'b0, 1'b0, 10, 1'b0);

    issue(1'b0, 8'd100, 8'd3);
    wait_res("ce_tog", 8'd33, 8'd1, 1'b0, 1'b0, 20, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
